// File: rtl/gray_stream_packer.sv
// Packs a vsync/href/strobe gray camera stream into a fixed-geometry {sof, gray[7:0]} pixel stream.
// Define GRAY_PACKER_PAD_EN to build the PAD state that fills short lines with the last accepted pixel.
module gray_stream_packer #(
  parameter int frame_width  = 128,
  parameter int frame_height = 96
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        cam_valid,
  output logic [8:0]  pixel_out,
  output logic        pixel_out_valid,
  output logic        frame_done,
  output logic        line_error,
  output logic        frame_error,
  output logic [15:0] row_count
);

  localparam int CW = $clog2(frame_width + 1);
  localparam logic [CW-1:0] COL_MAX  = CW'(frame_width);
  localparam logic [CW-1:0] COL_LAST = CW'(frame_width - 1);
  localparam logic [15:0]   ROW_LAST = 16'(frame_height - 1);

  typedef enum logic [1:0] {
    WAIT_FRAME,
    LINE_IDLE,
    ACTIVE
`ifdef GRAY_PACKER_PAD_EN
    , PAD
`endif
  } state_t;

  state_t          state, state_n;
  logic            vsync_q;
  logic [CW-1:0]   col, col_n;
  logic [15:0]     row, row_n;
  logic [7:0]      last_pixel, last_n;
  logic            sof_pending, sof_n;
  logic            err_seen, err_n;
  logic            drop_line, drop_n;
  logic [8:0]      pix_n;
  logic            vld_n, done_n, lerr_n, ferr_n;
  logic            accept, line_end;
`ifdef GRAY_PACKER_PAD_EN
  logic            pad_emit;
`endif

  assign row_count = row;

  always_comb begin
    state_n  = state;
    col_n    = col;
    row_n    = row;
    last_n   = last_pixel;
    sof_n    = sof_pending;
    err_n    = err_seen;
    drop_n   = drop_line;
    pix_n    = '0;
    vld_n    = 1'b0;
    done_n   = 1'b0;
    lerr_n   = 1'b0;
    ferr_n   = 1'b0;
    line_end = 1'b0;
`ifdef GRAY_PACKER_PAD_EN
    pad_emit = 1'b0;
`endif
    accept = (state == LINE_IDLE || state == ACTIVE) && cam_href && cam_valid &&
             (col < COL_MAX) && !drop_line;

    if (state != WAIT_FRAME && cam_vsync) begin
      ferr_n  = 1'b1;
      state_n = WAIT_FRAME;
      col_n   = '0;
      row_n   = '0;
      err_n   = 1'b0;
      drop_n  = 1'b0;
    end else begin
      if (accept) begin
        pix_n  = {sof_pending, cam_data};
        vld_n  = 1'b1;
        col_n  = col + 1'b1;
        last_n = cam_data;
        sof_n  = 1'b0;
        if (col == COL_LAST && row == ROW_LAST) done_n = 1'b1;
      end

      case (state)
        WAIT_FRAME: begin
          if (!cam_vsync && vsync_q) begin
            state_n = LINE_IDLE;
            col_n   = '0;
            row_n   = '0;
            sof_n   = 1'b1;
            err_n   = 1'b0;
            drop_n  = 1'b0;
          end
        end
        LINE_IDLE: begin
          if (cam_href) state_n = ACTIVE;
        end
        ACTIVE: begin
          if (cam_href) begin
            if (cam_valid && col == COL_MAX && !err_seen) begin
              lerr_n = 1'b1;
              err_n  = 1'b1;
            end
          end else if (col == COL_MAX) begin
            line_end = 1'b1;
          end else begin
            lerr_n = 1'b1;
            err_n  = 1'b1;
`ifdef GRAY_PACKER_PAD_EN
            pad_emit = 1'b1;
`else
            line_end = 1'b1;
            if (row == ROW_LAST) done_n = 1'b1;
`endif
          end
        end
`ifdef GRAY_PACKER_PAD_EN
        PAD: begin
          pad_emit = 1'b1;
          if (cam_valid && !err_seen) begin
            lerr_n = 1'b1;
            err_n  = 1'b1;
          end
        end
`endif
        default: ;
      endcase

`ifdef GRAY_PACKER_PAD_EN
      // The first pad pixel is emitted in the same cycle the short line is detected.
      if (pad_emit) begin
        pix_n  = {sof_pending, last_pixel};
        vld_n  = 1'b1;
        sof_n  = 1'b0;
        col_n  = col + 1'b1;
        drop_n = 1'b0;
        if (col == COL_LAST) begin
          line_end = 1'b1;
          if (row == ROW_LAST) done_n = 1'b1;
          drop_n = cam_href;
        end else begin
          state_n = PAD;
        end
      end
`endif

      if (line_end) begin
        col_n = '0;
        err_n = 1'b0;
        if (row == ROW_LAST) begin
          state_n = WAIT_FRAME;
        end else begin
          row_n   = row + 16'd1;
          state_n = LINE_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= WAIT_FRAME;
      vsync_q         <= 1'b0;
      col             <= '0;
      row             <= '0;
      last_pixel      <= '0;
      sof_pending     <= 1'b0;
      err_seen        <= 1'b0;
      drop_line       <= 1'b0;
      pixel_out       <= '0;
      pixel_out_valid <= 1'b0;
      frame_done      <= 1'b0;
      line_error      <= 1'b0;
      frame_error     <= 1'b0;
    end else begin
      state           <= state_n;
      vsync_q         <= cam_vsync;
      col             <= col_n;
      row             <= row_n;
      last_pixel      <= last_n;
      sof_pending     <= sof_n;
      err_seen        <= err_n;
      drop_line       <= drop_n;
      pixel_out       <= pix_n;
      pixel_out_valid <= vld_n;
      frame_done      <= done_n;
      line_error      <= lerr_n;
      frame_error     <= ferr_n;
    end
  end

endmodule

// File: tb/tb_gray_stream_packer.sv
// Self-checking bench for gray_stream_packer: line-level reference model plus directed literal checks.
module tb_gray_stream_packer;
  localparam int W = 8;
  localparam int H = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = '0;
  logic        cam_valid = 1'b0;
  logic [8:0]  pixel_out;
  logic        pixel_out_valid;
  logic        frame_done;
  logic        line_error;
  logic        frame_error;
  logic [15:0] row_count;

  gray_stream_packer #(.frame_width(W), .frame_height(H)) dut (
    .clk(clk), .reset_n(reset_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .cam_valid(cam_valid), .pixel_out(pixel_out),
    .pixel_out_valid(pixel_out_valid), .frame_done(frame_done), .line_error(line_error),
    .frame_error(frame_error), .row_count(row_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct { bit v; logic [8:0] pix; bit done; } ev_t;
  typedef struct { logic [8:0] pix; bit done; int cyc; } beat_t;
  ev_t   exp_q[$];
  beat_t log_q[$];
  int    lerr_seen = 0;
  int    ferr_seen = 0;

  logic [7:0] m_last = '0;
  bit         m_sof = 1'b0;
  int         m_row = 0;
  int         m_lerr = 0;
  int         m_ferr = 0;
  int         first_cyc = 0;
  int         fall_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : compare
    ev_t e;
    logic [10:0] act;
    if (reset_n) begin
      if (pixel_out_valid || frame_done) begin
        act = {pixel_out_valid, pixel_out_valid ? pixel_out : 9'h0, frame_done};
        if (exp_q.size() == 0) begin
          check("spurious_output", 32'(act), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("output_beat", 32'(act), 32'({e.v, e.v ? e.pix : 9'h0, e.done}));
        end
        if (pixel_out_valid) log_q.push_back('{pixel_out, frame_done, cyc});
      end
      if (line_error)  lerr_seen++;
      if (frame_error) ferr_seen++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Whole-line reference: what a line of n strobes must turn into downstream.
  task automatic model_line(input logic [7:0] d[$], input bit last_row);
    int n = d.size();
    int k = (n < W) ? n : W;
    for (int i = 0; i < k; i++) begin
      exp_q.push_back('{1'b1, {m_sof, d[i]}, last_row && (i == W - 1)});
      m_sof  = 1'b0;
      m_last = d[i];
    end
`ifdef GRAY_PACKER_PAD_EN
    for (int j = k; j < W; j++) begin
      exp_q.push_back('{1'b1, {m_sof, m_last}, last_row && (j == W - 1)});
      m_sof = 1'b0;
    end
`else
    if (k < W && last_row) exp_q.push_back('{1'b0, 9'h0, 1'b1});
`endif
    if (n != W) m_lerr++;
    if (!last_row) m_row++;
  endtask

  task automatic drive_line(input logic [7:0] d[$], input bit last_row, input int max_idle);
    model_line(d, last_row);
    cam_href  = 1'b1;
    cam_valid = 1'b0;
    if (d.size() == 0) begin
      step();
      step();
    end
    for (int i = 0; i < d.size(); i++) begin
      repeat ($urandom_range(0, max_idle)) begin
        cam_valid = 1'b0;
        step();
      end
      if (i == 0) first_cyc = cyc;
      cam_valid = 1'b1;
      cam_data  = d[i];
      step();
    end
    cam_valid = 1'b0;
    repeat ($urandom_range(0, max_idle)) step();
    cam_href = 1'b0;
    fall_cyc = cyc;
    repeat (W + 3) step();
    check("row_count", 32'(row_count), 32'(m_row));
    check("line_error_count", 32'(lerr_seen), 32'(m_lerr));
  endtask

  task automatic start_frame();
    cam_vsync = 1'b1;
    repeat (3) step();
    cam_vsync = 1'b0;
    repeat (2) step();
    m_sof = 1'b1;
    m_row = 0;
    check("row_after_vsync_fall", 32'(row_count), 32'd0);
  endtask

  task automatic abort_frame();
    cam_vsync = 1'b1;
    repeat (3) step();
    m_ferr++;
    m_row = 0;
    check("frame_error_count", 32'(ferr_seen), 32'(m_ferr));
    check("row_after_abort", 32'(row_count), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, 32'({pixel_out, pixel_out_valid, frame_done, line_error, frame_error, row_count}), 32'd0);
  endtask

  initial begin
    logic [7:0] d[$];
    int fc, fall0, lbase, nlog;

    #2 reset_n = 1'b0;
    repeat (3) begin
      step();
      check_reset_outputs("reset_outputs");
    end
    reset_n = 1'b1;
    step();

    // Frame A: two full lines of 1..8.
    start_frame();
    log_q.delete();
    lbase = lerr_seen;
    fc = 0;
    for (int l = 0; l < H; l++) begin
      d.delete();
      for (int i = 1; i <= 8; i++) d.push_back(8'(i));
      drive_line(d, l == H - 1, 0);
      if (l == 0) fc = first_cyc;
    end
    check("a_count", 32'(log_q.size()), 32'd16);
    check("a_first_sof", 32'(log_q[0].pix), 32'h101);
    check("a_latency", 32'(log_q[0].cyc), 32'(fc + 1));
    check("a_line1_first", 32'(log_q[8].pix), 32'h001);
    check("a_last", 32'(log_q[15].pix), 32'h008);
    check("a_frame_done", 32'(log_q[15].done), 32'd1);
    check("a_no_line_error", 32'(lerr_seen - lbase), 32'd0);

    // Frame B: short line 10..14, then long line 20..30.
    start_frame();
    log_q.delete();
    lbase = lerr_seen;
    d.delete();
    for (int i = 10; i <= 14; i++) d.push_back(8'(i));
    drive_line(d, 1'b0, 0);
    fall0 = fall_cyc;
    check("b_row_after_short", 32'(row_count), 32'd1);
    d.delete();
    for (int i = 20; i <= 30; i++) d.push_back(8'(i));
    drive_line(d, 1'b1, 0);
    check("b_first_sof", 32'(log_q[0].pix), 32'h10A);
    check("b_line_errors", 32'(lerr_seen - lbase), 32'd2);
`ifdef GRAY_PACKER_PAD_EN
    check("b_count", 32'(log_q.size()), 32'd16);
    check("b_pad0", 32'(log_q[5].pix), 32'h00E);
    check("b_pad1", 32'(log_q[6].pix), 32'h00E);
    check("b_pad2", 32'(log_q[7].pix), 32'h00E);
    check("b_pad_start", 32'(log_q[5].cyc), 32'(fall0 + 1));
    check("b_pad_back_to_back", 32'(log_q[7].cyc), 32'(fall0 + 3));
    check("b_long_first", 32'(log_q[8].pix), 32'h014);
    check("b_long_last", 32'(log_q[15].pix), 32'h01B);
    check("b_frame_done", 32'(log_q[15].done), 32'd1);
`else
    check("b_count", 32'(log_q.size()), 32'd13);
    check("b_short_last", 32'(log_q[4].pix), 32'h00E);
    check("b_short_last_cyc", 32'(log_q[4].cyc), 32'(fall0));
    check("b_long_first", 32'(log_q[5].pix), 32'h014);
    check("b_long_last", 32'(log_q[12].pix), 32'h01B);
    check("b_frame_done", 32'(log_q[12].done), 32'd1);
`endif

    // Frame C: aborted after line 0; frame D must restart with SOF.
    start_frame();
    d.delete();
    for (int i = 0; i < W; i++) d.push_back(8'($urandom));
    drive_line(d, 1'b0, 2);
    abort_frame();
    start_frame();
    log_q.delete();
    for (int l = 0; l < H; l++) begin
      d.delete();
      for (int i = 0; i < W; i++) d.push_back(8'($urandom));
      drive_line(d, l == H - 1, 1);
    end
    check("d_sof_after_abort", 32'(log_q[0].pix[8]), 32'd1);

    // Randomized frames with short, empty, long lines and aborts.
    for (int f = 0; f < 25; f++) begin
      start_frame();
      for (int l = 0; l < H; l++) begin
        int n = $urandom_range(0, W + 3);
        if ($urandom_range(0, 1) == 1) n = W;
        d.delete();
        for (int i = 0; i < n; i++) d.push_back(8'($urandom));
        drive_line(d, l == H - 1, 2);
        if (l == 0 && $urandom_range(0, 4) == 0) begin
          abort_frame();
          break;
        end
      end
    end

    // Reset in the middle of a line, released while the camera keeps streaming.
    start_frame();
    d.delete();
    d.push_back(8'h55);
    d.push_back(8'h66);
    d.push_back(8'h77);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{1'b1, {m_sof, d[i]}, 1'b0});
      m_sof = 1'b0;
    end
    cam_href = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cam_valid = 1'b1;
      cam_data  = d[i];
      step();
    end
    cam_valid = 1'b0;
    repeat (2) step();
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midline_reset_outputs");
    repeat (2) begin
      step();
      check_reset_outputs("midline_reset_outputs");
    end
    nlog = log_q.size();
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cam_valid = i[0];
      cam_data  = 8'($urandom);
      step();
    end
    cam_valid = 1'b0;
    cam_href  = 1'b0;
    repeat (2) step();
    check("no_output_after_reset", 32'(log_q.size()), 32'(nlog));
    check("expect_queue_drained", 32'(exp_q.size()), 32'd0);
    m_last = '0;
    m_row  = 0;

    for (int f = 0; f < 5; f++) begin
      start_frame();
      for (int l = 0; l < H; l++) begin
        int n = $urandom_range(0, W + 2);
        d.delete();
        for (int i = 0; i < n; i++) d.push_back(8'($urandom));
        drive_line(d, l == H - 1, 2);
      end
    end

    repeat (4) step();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_line_errors", 32'(lerr_seen), 32'(m_lerr));
    check("final_frame_errors", 32'(ferr_seen), 32'(m_ferr));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
